sample_packer: RTL and testbench
================================

# sample_packer

Packs captured samples into 32-bit memory words for the SRAM write stream. It drops disabled channel groups (bytes) and compacts the enabled bytes back to back, so no word carries a hole. It sits between the capture/trigger path and the SRAM interface. It drives that interface's `mwr_*` port with one word per fully-filled line and a final partial word flagged with `tlast`/`tkeep`.

## Interface
- `SDW`, 32 — sample width in bits (4 byte groups)
- `MDW`, 32 — memory data width in bits
- `MKW`, 4 — keep width in bits (one keep bit per byte lane)

Ports:
- `clk`  in  1 — clock; all logic is on its rising edge
- `rst`  in  1 — asynchronous, active-low reset
- `cfg_init`  in  1 — synchronous restart; latches `cfg_disable`
- `cfg_disable`  in  4 — group disable mask; bit i=1 drops byte i of each sample
- `sti_tvalid`  in  1 — sample valid
- `sti_tready`  out  1 — sample accepted when high together with `sti_tvalid`
- `sti_tlast`  in  1 — last sample of capture; forces a flush
- `sti_tdata`  in  SDW — sample
- `mwr_tready`  in  1 — SRAM side ready
- `mwr_tvalid`  out  1 — word valid
- `mwr_tlast`  out  1 — final word of capture
- `mwr_tkeep`  out  MKW — valid byte lanes, contiguous from lane 0
- `mwr_tdata`  out  MDW — packed word

## Operation
- **Group mask.** `dis_r` holds the latched disable mask.
  - Loaded from `cfg_disable` on any cycle with `cfg_init=1`.
  - Reset value is 4'b0000.
  - N = popcount(~dis_r), range 0..4.
- **Compaction.** The enabled bytes of an accepted sample are compacted with the lowest group first.
  - They are appended to the accumulator at byte offset `fill` (0..3).
  - The earliest byte lands in lane 0.
  - The accumulator is 7 bytes wide.
- **Word emission.** Let S = `fill` + N.
  - If S ≥ 4: emit lanes 0..3 with keep 4'b1111; shift the remainder down; `fill` ← S−4.
  - If S < 4: no word is emitted; `fill` ← S.
- **States:** PACK, FLUSH.
- **PACK.**
  - `sti_tready` = !`mwr_tvalid` | `mwr_tready`.
  - On accept with `sti_tlast=1`:
    - S < 4: emit one word with keep = (1<<S)−1 and `tlast=1`. If S=0, emit nothing.
    - S = 4: emit the full word with `tlast=1`.
    - S > 4: emit the full word with `tlast=0`, then go to FLUSH.
  - In every `tlast` case, `fill` ends at 0.
- **FLUSH.**
  - `sti_tready=0`.
  - When the output slot is free, emit the remainder word: keep = (1<<(S−4))−1, `tlast=1`.
  - Then `fill` ← 0 and return to PACK.
- **N = 0.** Samples are accepted and discarded. If `tlast` arrives with `fill`>0, the partial word is flushed with `tlast=1`.
- **`cfg_init`.** Takes priority over everything else in that cycle:
  - `fill` ← 0, state ← PACK.
  - `mwr_tvalid` ← 0; a pending word is discarded.
  - Any sample presented in that cycle is ignored.
- Unused lanes of `mwr_tdata` (keep=0) are driven 0.

## Timing
- **Reset values:** `mwr_tvalid`=0, `mwr_tlast`=0, `mwr_tkeep`=0, `mwr_tdata`=0, state=PACK, `fill`=0. `sti_tready`=1 after reset.
- **Latency:** one cycle from sample accept to `mwr_tvalid`. A single output register is used, so there is no skid buffer.
- **Throughput:** one sample per cycle while `mwr_tready`=1.
- **Exception:** the one FLUSH cycle per `tlast` with S > 4.
- **Backpressure:** while `mwr_tvalid=1` and `mwr_tready=0`, all `mwr_*` outputs hold stable and `sti_tready=0`.
- **Reset mid-stream:** async assertion clears everything immediately. The partial word is lost by design.

## Configuration
- **`SAMPLE_PACKER_WORDCNT_EN` defined:**
  - Adds output `cnt_words` (16 bits).
  - Counts words transferred (`mwr_tvalid & mwr_tready`).
  - Saturates at 16'hFFFF.
  - Cleared by `rst` and by `cfg_init`.
- **Undefined:** the port and the counter do not exist.

## Test plan
- **All groups enabled.**
  - Stimulus: mask 0000; samples 0x03020100, 0x07060504; tlast on the second.
  - Required: two words, each keep 1111, equal to the inputs; tlast only on the second.
- **Three groups.**
  - Stimulus: mask 1000; samples 0x..020100, 0x..050403, 0x..080706 with tlast.
  - Required: word 0x03020100 keep 1111, then 0x07060504 keep 1111, then 0x00000008 keep 0001 with tlast.
  - Required: `sti_tready` low for exactly one cycle (FLUSH).
- **One group.**
  - Stimulus: mask 1110; five samples with bytes 0x10..0x14; tlast on the fifth.
  - Required: 0x13121110 keep 1111, then 0x00000014 keep 0001 with tlast.
- **Backpressure.**
  - Stimulus: hold `mwr_tready`=0 for 5 cycles with a word pending.
  - Required: `mwr_*` stable and `sti_tready`=0 for those cycles; no sample lost or duplicated after release.
- **`cfg_init` mid-capture.**
  - Stimulus: pulse `cfg_init` with mask 1100 while `fill`=2 and a word is pending.
  - Required: the pending word is dropped, and the next two samples yield one word with keep 1111.
- **Reset.**
  - Stimulus: assert `rst`=0 asynchronously during FLUSH.
  - Required: outputs reach reset values without a clock edge; `sti_tready`=1 after release.

Source files
------------

// File: rtl/sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : sample_packer
// Brief    : Drops disabled byte groups and packs the enabled bytes into 32-bit
//            words for the SRAM write stream. Optional word counter behind
//            SAMPLE_PACKER_WORDCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sample_packer #(
  parameter int SDW = 32,
  parameter int MDW = 32,
  parameter int MKW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_init,
  input  logic [MKW-1:0]   cfg_disable,
  input  logic             sti_tvalid,
  output logic             sti_tready,
  input  logic             sti_tlast,
  input  logic [SDW-1:0]   sti_tdata,
  input  logic             mwr_tready,
  output logic             mwr_tvalid,
  output logic             mwr_tlast,
  output logic [MKW-1:0]   mwr_tkeep,
  output logic [MDW-1:0]   mwr_tdata
`ifdef SAMPLE_PACKER_WORDCNT_EN
  ,
  output logic [15:0]      cnt_words
`endif
);

  localparam int c_NB   = SDW / 8;
  localparam int c_ACCW = SDW + MDW - 8;
  localparam int c_REMW = MDW - 8;

  typedef enum logic [0:0] {
    ST_PACK  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t            r_state,  w_state_nxt;
  logic [c_NB-1:0]   r_dis,    w_dis_nxt;
  logic [1:0]        r_fill,   w_fill_nxt;
  logic [c_REMW-1:0] r_acc,    w_acc_nxt;
  logic              r_tvalid, w_tvalid_nxt;
  logic              r_tlast,  w_tlast_nxt;
  logic [MKW-1:0]    r_tkeep,  w_tkeep_nxt;
  logic [MDW-1:0]    r_tdata,  w_tdata_nxt;

  logic [SDW-1:0]    w_cmp;
  logic [2:0]        w_n;
  logic [2:0]        w_sum;
  logic [c_ACCW-1:0] w_acc;
  logic              w_slot_free;
  logic              w_accept;

  function automatic logic [MKW-1:0] keep_of(input logic [2:0] n);
    keep_of = MKW'((32'd1 << n) - 32'd1);
  endfunction

  assign w_slot_free = !r_tvalid || mwr_tready;
  assign sti_tready  = (r_state == ST_PACK) && w_slot_free;
  assign w_accept    = sti_tvalid && sti_tready && !cfg_init;

  // Enabled bytes move down to the lowest free slot, lowest group first.
  always_comb begin
    int k;
    w_cmp = '0;
    k     = 0;
    for (int i = 0; i < c_NB; i++) begin
      if (!r_dis[i]) begin
        w_cmp[k*8 +: 8] = sti_tdata[i*8 +: 8];
        k = k + 1;
      end
    end
    w_n = 3'(k);
  end

  assign w_sum = {1'b0, r_fill} + w_n;
  assign w_acc = {{(c_ACCW-c_REMW){1'b0}}, r_acc}
               | ({{(c_ACCW-SDW){1'b0}}, w_cmp} << {r_fill, 3'b000});

  always_comb begin
    w_state_nxt  = r_state;
    w_dis_nxt    = r_dis;
    w_fill_nxt   = r_fill;
    w_acc_nxt    = r_acc;
    w_tvalid_nxt = r_tvalid;
    w_tlast_nxt  = r_tlast;
    w_tkeep_nxt  = r_tkeep;
    w_tdata_nxt  = r_tdata;

    if (cfg_init) begin
      w_state_nxt  = ST_PACK;
      w_dis_nxt    = cfg_disable;
      w_fill_nxt   = '0;
      w_acc_nxt    = '0;
      w_tvalid_nxt = 1'b0;
      w_tlast_nxt  = 1'b0;
      w_tkeep_nxt  = '0;
      w_tdata_nxt  = '0;
    end else begin
      if (r_tvalid && mwr_tready) begin
        w_tvalid_nxt = 1'b0;
        w_tlast_nxt  = 1'b0;
        w_tkeep_nxt  = '0;
        w_tdata_nxt  = '0;
      end

      case (r_state)
        ST_PACK: begin
          if (w_accept) begin
            if (w_sum >= 3'd4) begin
              w_tvalid_nxt = 1'b1;
              w_tkeep_nxt  = '1;
              w_tdata_nxt  = w_acc[MDW-1:0];
              w_tlast_nxt  = sti_tlast && (w_sum == 3'd4);
              // S-4 is just the low two bits of S in the range 4..7.
              w_fill_nxt   = w_sum[1:0];
              w_acc_nxt    = w_acc[c_ACCW-1:MDW];
              if (sti_tlast) begin
                if (w_sum == 3'd4) begin
                  w_fill_nxt = '0;
                  w_acc_nxt  = '0;
                end else begin
                  w_state_nxt = ST_FLUSH;
                end
              end
            end else if (sti_tlast) begin
              w_fill_nxt = '0;
              w_acc_nxt  = '0;
              if (w_sum != 3'd0) begin
                w_tvalid_nxt = 1'b1;
                w_tlast_nxt  = 1'b1;
                w_tkeep_nxt  = keep_of(w_sum);
                w_tdata_nxt  = w_acc[MDW-1:0];
              end
            end else begin
              w_fill_nxt = w_sum[1:0];
              w_acc_nxt  = w_acc[c_REMW-1:0];
            end
          end
        end
        ST_FLUSH: begin
          if (w_slot_free) begin
            w_tvalid_nxt = 1'b1;
            w_tlast_nxt  = 1'b1;
            w_tkeep_nxt  = keep_of({1'b0, r_fill});
            w_tdata_nxt  = {8'h00, r_acc};
            w_fill_nxt   = '0;
            w_acc_nxt    = '0;
            w_state_nxt  = ST_PACK;
          end
        end
        default: w_state_nxt = ST_PACK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_PACK;
      r_dis    <= '0;
      r_fill   <= '0;
      r_acc    <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tkeep  <= '0;
      r_tdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_dis    <= w_dis_nxt;
      r_fill   <= w_fill_nxt;
      r_acc    <= w_acc_nxt;
      r_tvalid <= w_tvalid_nxt;
      r_tlast  <= w_tlast_nxt;
      r_tkeep  <= w_tkeep_nxt;
      r_tdata  <= w_tdata_nxt;
    end
  end

  assign mwr_tvalid = r_tvalid;
  assign mwr_tlast  = r_tlast;
  assign mwr_tkeep  = r_tkeep;
  assign mwr_tdata  = r_tdata;

`ifdef SAMPLE_PACKER_WORDCNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (cfg_init) begin
      r_cnt <= '0;
    end else if (r_tvalid && mwr_tready && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign cnt_words = r_cnt;
`else
  // No transferred-word counter in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_packer
// Brief    : Directed self-checking bench for sample_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_init = 1'b0;
  logic [3:0]  cfg_disable = 4'h0;
  logic        sti_tvalid = 1'b0;
  logic        sti_tready;
  logic        sti_tlast = 1'b0;
  logic [31:0] sti_tdata = 32'h0;
  logic        mwr_tready = 1'b1;
  logic        mwr_tvalid;
  logic        mwr_tlast;
  logic [3:0]  mwr_tkeep;
  logic [31:0] mwr_tdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sample_packer #(.SDW(32), .MDW(32), .MKW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_init    (cfg_init),
    .cfg_disable (cfg_disable),
    .sti_tvalid  (sti_tvalid),
    .sti_tready  (sti_tready),
    .sti_tlast   (sti_tlast),
    .sti_tdata   (sti_tdata),
    .mwr_tready  (mwr_tready),
    .mwr_tvalid  (mwr_tvalid),
    .mwr_tlast   (mwr_tlast),
    .mwr_tkeep   (mwr_tkeep),
    .mwr_tdata   (mwr_tdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic v, input logic l,
                          input logic [3:0] k, input logic [31:0] d);
    chk({tag, ".tvalid"}, 64'(mwr_tvalid), 64'(v));
    chk({tag, ".tlast"},  64'(mwr_tlast),  64'(l));
    chk({tag, ".tkeep"},  64'(mwr_tkeep),  64'(k));
    chk({tag, ".tdata"},  64'(mwr_tdata),  64'(d));
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    sti_tvalid = 1'b1;
    sti_tdata  = d;
    sti_tlast  = last;
    tick();
    sti_tvalid = 1'b0;
    sti_tlast  = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] m);
    cfg_init    = 1'b1;
    cfg_disable = m;
    tick();
    cfg_init    = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    chk_word("reset", 1'b0, 1'b0, 4'h0, 32'h0);
    chk("reset.sti_tready", 64'(sti_tready), 64'd1);
    rst = 1'b1;
    tick();

    // All groups enabled
    cfg(4'b0000);
    send(32'h03020100, 1'b0);
    chk_word("all.w0", 1'b1, 1'b0, 4'hF, 32'h03020100);
    send(32'h07060504, 1'b1);
    chk_word("all.w1", 1'b1, 1'b1, 4'hF, 32'h07060504);
    tick();
    chk("all.idle", 64'(mwr_tvalid), 64'd0);

    // Three groups, flush on tlast
    cfg(4'b1000);
    send(32'hAA020100, 1'b0);
    chk("three.none", 64'(mwr_tvalid), 64'd0);
    send(32'hBB050403, 1'b0);
    chk_word("three.w0", 1'b1, 1'b0, 4'hF, 32'h03020100);
    send(32'hCC080706, 1'b1);
    chk_word("three.w1", 1'b1, 1'b0, 4'hF, 32'h07060504);
    chk("three.flush_tready", 64'(sti_tready), 64'd0);
    tick();
    chk_word("three.w2", 1'b1, 1'b1, 4'h1, 32'h00000008);
    chk("three.tready_back", 64'(sti_tready), 64'd1);
    tick();

    // One group
    cfg(4'b1110);
    send(32'hFFFFFF10, 1'b0);
    send(32'hFFFFFF11, 1'b0);
    send(32'hFFFFFF12, 1'b0);
    chk("one.none", 64'(mwr_tvalid), 64'd0);
    send(32'hFFFFFF13, 1'b0);
    chk_word("one.w0", 1'b1, 1'b0, 4'hF, 32'h13121110);
    send(32'hFFFFFF14, 1'b1);
    chk_word("one.w1", 1'b1, 1'b1, 4'h1, 32'h00000014);
    tick();

    // Backpressure
    cfg(4'b0000);
    mwr_tready = 1'b0;
    send(32'h44332211, 1'b0);
    sti_tvalid = 1'b1;
    sti_tdata  = 32'h88776655;
    for (int c = 0; c < 5; c++) begin
      chk("bp.sti_tready", 64'(sti_tready), 64'd0);
      chk_word("bp.hold", 1'b1, 1'b0, 4'hF, 32'h44332211);
      tick();
    end
    mwr_tready = 1'b1;
    #1;
    chk("bp.release_tready", 64'(sti_tready), 64'd1);
    tick();
    sti_tvalid = 1'b0;
    chk_word("bp.next", 1'b1, 1'b0, 4'hF, 32'h88776655);
    tick();
    chk("bp.no_dup", 64'(mwr_tvalid), 64'd0);

    // cfg_init mid-capture with a pending word and fill=2
    cfg(4'b1000);
    send(32'h00C2C1C0, 1'b0);
    send(32'h00C5C4C3, 1'b0);
    chk_word("init.pending", 1'b1, 1'b0, 4'hF, 32'hC3C2C1C0);
    mwr_tready  = 1'b0;
    sti_tvalid  = 1'b1;
    sti_tdata   = 32'hDEADBEEF;
    cfg(4'b1100);
    sti_tvalid  = 1'b0;
    mwr_tready  = 1'b1;
    chk_word("init.dropped", 1'b0, 1'b0, 4'h0, 32'h0);
    send(32'hEEEEBBAA, 1'b0);
    chk("init.none", 64'(mwr_tvalid), 64'd0);
    send(32'hEEEEDDCC, 1'b0);
    chk_word("init.w0", 1'b1, 1'b0, 4'hF, 32'hDDCCBBAA);
    tick();
    chk("init.idle", 64'(mwr_tvalid), 64'd0);

    // Asynchronous reset during FLUSH
    cfg(4'b1000);
    send(32'h00030201, 1'b0);
    send(32'h00060504, 1'b1);
    chk_word("rst.pre", 1'b1, 1'b0, 4'hF, 32'h04030201);
    chk("rst.in_flush", 64'(sti_tready), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    chk_word("rst.async", 1'b0, 1'b0, 4'h0, 32'h0);
    chk("rst.async_tready", 64'(sti_tready), 64'd1);
    rst = 1'b1;
    tick();
    chk("rst.after_tvalid", 64'(mwr_tvalid), 64'd0);
    chk("rst.after_tready", 64'(sti_tready), 64'd1);
    send(32'h12345678, 1'b0);
    chk_word("rst.mask_cleared", 1'b1, 1'b0, 4'hF, 32'h12345678);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
